// File: rtl/uart_msg_pkg.sv
// Shared types for the UART message framer: FSM states, default sync marker,
// and the 8-bit length and checksum types.
package uart_msg_pkg;
   typedef enum logic [2:0] {
      ST_HUNT,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM,
      ST_DRAIN
   } state_t;

   typedef logic [7:0] sum_t;
   typedef logic [7:0] len_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_msg_buf.sv
// Payload store: MAX_LEN x 8 register file with one synchronous write port and
// one combinational read port. The parent owns both pointers.
module uart_msg_buf #(
   parameter int MAX_LEN = 16,
   parameter int AW      = 4
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [7:0]    i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [7:0]    o_rd_data
);
   logic [7:0] r_mem [MAX_LEN];

   // Never cleared; each frame simply overwrites what the previous one left.
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/uart_msg_framer.sv
// Sync-hunting frame controller: LEN/PAYLOAD/CSUM sequencing, buffered drain over valid/ready.
// UART_MSG_TIMEOUT_EN builds the inter-byte timeout counter; otherwise err_timeout is tied low.
module uart_msg_framer
   import uart_msg_pkg::*;
#(
   parameter int         MAX_LEN      = 16,
   parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT,
   parameter int         TIMEOUT_CLKS = 200000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic [7:0] msg_len,
   output logic       busy,
   output logic       err_csum,
   output logic       err_len,
   output logic       err_ovr,
   output logic       err_timeout
);
   localparam int   AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam len_t MAX_LEN_B = len_t'(MAX_LEN);

   state_t     r_state;
   len_t       r_len;
   sum_t       r_sum;
   len_t       r_wr_ptr;
   len_t       r_rd_ptr;
   logic       r_err_csum;
   logic       r_err_len;
   logic       r_err_ovr;
   logic       r_err_timeout;
   logic       w_wr_en;
   logic       w_last;
   logic       w_timeout;
   logic [7:0] w_rd_data;

   assign w_wr_en = byte_valid && (r_state == ST_PAYLOAD);
   assign w_last  = (r_rd_ptr == r_len - 8'd1);

`ifdef UART_MSG_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);

   logic [TW-1:0] r_to_cnt;
   logic          w_in_frame;

   assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
   assign w_timeout  = w_in_frame && !byte_valid && (r_to_cnt == TW'(TIMEOUT_CLKS - 1));

   // Held at zero outside the frame states, so every entry starts a fresh count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (!w_in_frame || byte_valid || w_timeout) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_HUNT;
         r_len         <= '0;
         r_sum         <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_err_csum    <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_ovr     <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_err_csum    <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_ovr     <= 1'b0;
         r_err_timeout <= 1'b0;
         if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_HUNT;
         end else begin
            case (r_state)
               ST_HUNT: begin
                  if (byte_valid && (byte_data == SYNC_BYTE)) r_state <= ST_LEN;
               end
               ST_LEN: begin
                  if (byte_valid) begin
                     if ((byte_data != 8'd0) && (byte_data <= MAX_LEN_B)) begin
                        r_len    <= byte_data;
                        r_sum    <= byte_data;
                        r_wr_ptr <= '0;
                        r_state  <= ST_PAYLOAD;
                     end else begin
                        r_err_len <= 1'b1;
                        r_state   <= ST_HUNT;
                     end
                  end
               end
               ST_PAYLOAD: begin
                  if (byte_valid) begin
                     r_sum    <= r_sum + byte_data;
                     r_wr_ptr <= r_wr_ptr + 8'd1;
                     if (r_wr_ptr == r_len - 8'd1) r_state <= ST_CSUM;
                  end
               end
               ST_CSUM: begin
                  if (byte_valid) begin
                     if (byte_data == r_sum) begin
                        r_rd_ptr <= '0;
                        r_state  <= ST_DRAIN;
                     end else begin
                        r_err_csum <= 1'b1;
                        r_state    <= ST_HUNT;
                     end
                  end
               end
               ST_DRAIN: begin
                  // The receiver cannot be stalled, so bytes arriving now are lost.
                  if (byte_valid) r_err_ovr <= 1'b1;
                  if (out_ready) begin
                     if (w_last) r_state <= ST_HUNT;
                     else        r_rd_ptr <= r_rd_ptr + 8'd1;
                  end
               end
               default: r_state <= ST_HUNT;
            endcase
         end
      end
   end

   uart_msg_buf #(
      .MAX_LEN (MAX_LEN),
      .AW      (AW)
   ) u_buf (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr[AW-1:0]),
      .i_wr_data (byte_data),
      .i_rd_addr (r_rd_ptr[AW-1:0]),
      .o_rd_data (w_rd_data)
   );

   assign out_valid   = (r_state == ST_DRAIN);
   assign out_data    = w_rd_data;
   assign out_last    = out_valid && w_last;
   assign msg_len     = r_len;
   assign busy        = (r_state != ST_HUNT);
   assign err_csum    = r_err_csum;
   assign err_len     = r_err_len;
   assign err_ovr     = r_err_ovr;
   assign err_timeout = r_err_timeout;
endmodule

// File: tb/tb_uart_msg_framer.sv
// Bench for uart_msg_framer: directed frames plus random frame mixes against a frame-level parser model.
module tb_uart_msg_framer;
   localparam int         MAXL = 16;
   localparam logic [7:0] SYNC = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic [7:0] msg_len;
   logic       busy;
   logic       err_csum;
   logic       err_len;
   logic       err_ovr;
   logic       err_timeout;

   uart_msg_framer #(
      .MAX_LEN      (MAXL),
      .SYNC_BYTE    (SYNC),
      .TIMEOUT_CLKS (50)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .msg_len     (msg_len),
      .busy        (busy),
      .err_csum    (err_csum),
      .err_len     (err_len),
      .err_ovr     (err_ovr),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad = 0;
   int n_len = 0, n_csum = 0, n_ovr = 0, n_to = 0;
   int b_len, b_csum, b_ovr, b_to;
   int e_len, e_csum;
   int to_cyc = 0;
   int last_cyc = 0;
   bit rdy_rand = 1'b0;

   logic [7:0] got_d[$];
   logic       got_l[$];
   logic [7:0] got_n[$];
   int         got_c[$];
   logic [7:0] exp_d[$];
   logic       exp_l[$];
   logic [7:0] exp_n[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Output monitor: handshakes, error pulses and hold-while-stalled behaviour.
   logic       stall_prev = 1'b0;
   logic [7:0] p_data, p_len;
   logic       p_last;
   always @(negedge clk) begin
      if (rst_n) begin
         if (err_len)     n_len++;
         if (err_csum)    n_csum++;
         if (err_ovr)     n_ovr++;
         if (err_timeout) begin n_to++; to_cyc = cyc; end
         if (stall_prev) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, p_data);
            check_eq("hold_last", out_last, p_last);
            check_eq("hold_len", msg_len, p_len);
         end
         stall_prev = out_valid && !out_ready;
         p_data = out_data; p_last = out_last; p_len = msg_len;
         if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
            got_n.push_back(msg_len);
            got_c.push_back(cyc);
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 9) < 7);
   endtask

   task automatic put_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      tick();
      last_cyc   = cyc;
      byte_valid = 1'b0;
   endtask

   task automatic feed(input logic [7:0] bq[$], input int maxgap);
      foreach (bq[i]) begin
         put_byte(bq[i]);
         if (i != bq.size() - 1) repeat ($urandom_range(0, maxgap)) tick();
      end
   endtask

   // Frame-level reference: scan the byte list for sync, then length, payload and checksum.
   task automatic model(input logic [7:0] bq[$]);
      int i, n, l;
      logic [7:0] s;
      i = 0;
      n = bq.size();
      while (i < n) begin
         if (bq[i] != SYNC) begin
            i++;
            continue;
         end
         if (i + 1 >= n) break;
         l = int'(bq[i+1]);
         i += 2;
         if (l == 0 || l > MAXL) begin
            e_len++;
            continue;
         end
         if (i + l >= n) break;
         s = 8'(l);
         for (int k = 0; k < l; k++) s += bq[i+k];
         if (bq[i+l] == s) begin
            for (int k = 0; k < l; k++) begin
               exp_d.push_back(bq[i+k]);
               exp_l.push_back(k == l - 1);
               exp_n.push_back(8'(l));
            end
         end else begin
            e_csum++;
         end
         i += l + 1;
      end
   endtask

   task automatic begin_chunk(input logic [7:0] bq[$]);
      b_len = n_len; b_csum = n_csum; b_ovr = n_ovr; b_to = n_to;
      e_len = 0; e_csum = 0;
      got_d.delete(); got_l.delete(); got_n.delete(); got_c.delete();
      exp_d.delete(); exp_l.delete(); exp_n.delete();
      model(bq);
   endtask

   task automatic end_chunk(input int exp_ovr, input int exp_to);
      for (int i = 0; i < 400; i++) begin
         tick();
         if (!busy) break;
      end
      check_eq("idle", busy, 0);
      check_eq("err_len_cnt", n_len - b_len, e_len);
      check_eq("err_csum_cnt", n_csum - b_csum, e_csum);
      check_eq("err_ovr_cnt", n_ovr - b_ovr, exp_ovr);
      check_eq("err_to_cnt", n_to - b_to, exp_to);
      check_eq("out_count", got_d.size(), exp_d.size());
      for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
         check_eq("out_data", got_d[k], exp_d[k]);
         check_eq("out_last", got_l[k], exp_l[k]);
         check_eq("msg_len", got_n[k], exp_n[k]);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_valid"}, out_valid, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_last"}, out_last, 0);
      check_eq({tag, "_len"}, msg_len, 0);
      check_eq({tag, "_errs"}, {err_csum, err_len, err_ovr, err_timeout}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t expected end earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bq[$];
      logic [7:0] b, s;
      int l, kind, saved;

      repeat (3) tick();
      check_outputs_zero("reset");
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();

      // Reference frame, back-to-back bytes, consumer always ready.
      bq = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      begin_chunk(bq);
      feed(bq, 0);
      saved = last_cyc;
      end_chunk(0, 0);
      check_eq("good_count", got_d.size(), 3);
      if (got_d.size() == 3) begin
         check_eq("good_first_cyc", got_c[0], saved);
         check_eq("good_b2b_1", got_c[1], got_c[0] + 1);
         check_eq("good_b2b_2", got_c[2], got_c[0] + 2);
      end

      bq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
      begin_chunk(bq);
      feed(bq, 0);
      end_chunk(0, 0);
      check_eq("badcsum_pulses", n_csum - b_csum, 1);

      bq = '{8'hA5, 8'h00};
      begin_chunk(bq); feed(bq, 0); end_chunk(0, 0);
      check_eq("len0_pulse", n_len - b_len, 1);
      bq = '{8'hA5, 8'h11};
      begin_chunk(bq); feed(bq, 0); end_chunk(0, 0);
      check_eq("len17_pulse", n_len - b_len, 1);

      bq = '{8'hA5, 8'h10};
      s = 8'h10;
      for (int k = 0; k < 16; k++) begin
         b = 8'($urandom_range(0, 255));
         bq.push_back(b);
         s += b;
      end
      bq.push_back(s);
      begin_chunk(bq); feed(bq, 0); end_chunk(0, 0);
      check_eq("max_len_count", got_d.size(), 16);

      // Backpressure: stall 5 cycles with a dropped byte in the middle.
      bq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      out_ready = 1'b0;
      begin_chunk(bq);
      feed(bq, 0);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_data", out_data, 8'h11);
      tick(); tick();
      put_byte(8'hA5);
      tick(); tick();
      check_eq("bp_ovr_data", out_data, 8'h11);
      check_eq("bp_ovr_pulse", n_ovr - b_ovr, 1);
      check_eq("bp_still_none", got_d.size(), 0);
      out_ready = 1'b1;
      end_chunk(1, 0);

`ifdef UART_MSG_TIMEOUT_EN
      bq = '{8'hA5, 8'h02, 8'h11};
      begin_chunk(bq);
      feed(bq, 0);
      saved = last_cyc;
      repeat (60) tick();
      check_eq("to_cycle", to_cyc, saved + 50);
      end_chunk(0, 1);
      bq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
      begin_chunk(bq); feed(bq, 0); end_chunk(0, 0);
      check_eq("to_next_count", got_d.size(), 1);
`endif

      // Reset in the middle of a frame discards it silently.
      bq = '{8'hA5, 8'h03, 8'h11};
      begin_chunk(bq);
      feed(bq, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_outputs_zero("midrst");
      end_chunk(0, 0);
      bq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      begin_chunk(bq); feed(bq, 0); end_chunk(0, 0);
      check_eq("after_rst_count", got_d.size(), 3);

      // Random mix of good, corrupted and bad-length frames with noise and random ready.
      rdy_rand = 1'b1;
      for (int f = 0; f < 30; f++) begin
         bq.delete();
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h00;
            bq.push_back(b);
         end
         bq.push_back(SYNC);
         kind = $urandom_range(0, 3);
         if (kind == 3) begin
            l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXL + 1, 255);
            bq.push_back(8'(l));
         end else begin
            l = $urandom_range(1, MAXL);
            bq.push_back(8'(l));
            s = 8'(l);
            for (int k = 0; k < l; k++) begin
               b = 8'($urandom_range(0, 255));
               bq.push_back(b);
               s += b;
            end
            if (kind == 2) s = s ^ (8'h01 << $urandom_range(0, 7));
            bq.push_back(s);
         end
         begin_chunk(bq);
         feed(bq, 2);
         end_chunk(0, 0);
      end
      rdy_rand = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_msg_framer.md
# uart_msg_framer

Byte-level frame controller that sits directly behind the UART receiver. It consumes the receiver's one-cycle `rdy` pulse and `data_out` byte, and hunts for a sync byte. It then sequences the length, payload and checksum fields, buffers the payload, and releases validated frames to the order-handling logic over a valid/ready byte stream. It adds the frame integrity checking that the raw receiver lacks.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum payload bytes per frame, from 1 to 255.
- `SYNC_BYTE`, 8'hA5: start-of-frame marker.
- `TIMEOUT_CLKS`, 200000: idle clocks allowed between bytes inside a frame.

Ports:
- `clk`, in, 1: single clock for the block.
- `rst_n`, in, 1: synchronous, active-low reset.
- `byte_valid`, in, 1: one-cycle strobe from the receiver's `rdy`.
- `byte_data`, in, 8: received byte, qualified by `byte_valid`.
- `out_valid`, out, 1: payload byte available.
- `out_ready`, in, 1: consumer accepts the byte.
- `out_data`, out, 8: payload byte.
- `out_last`, out, 1: final payload byte of the frame.
- `msg_len`, out, 8: payload length of the frame being drained.
- `busy`, out, 1: high whenever state is not HUNT.
- `err_csum`, out, 1: one-cycle pulse on checksum mismatch.
- `err_len`, out, 1: one-cycle pulse when LEN is 0 or greater than `MAX_LEN`.
- `err_ovr`, out, 1: one-cycle pulse when a byte is dropped during DRAIN.
- `err_timeout`, out, 1: one-cycle pulse on an inter-byte timeout.

## Operation
- States:
  - **HUNT**: `byte_valid` with `byte_data==SYNC_BYTE` moves to LEN. All other bytes are ignored silently.
  - **LEN**: on a byte, if 1 ≤ byte ≤ `MAX_LEN`, latch `len`, set `sum=byte`, clear `wr_ptr`, and move to PAYLOAD. Otherwise pulse `err_len` and move to HUNT.
  - **PAYLOAD**: on a byte, write `buf[wr_ptr]`, set `sum += byte` (mod 256), and increment `wr_ptr`. When `wr_ptr==len-1` at the write, move to CSUM.
  - **CSUM**: on a byte, if byte==`sum`, clear `rd_ptr` and move to DRAIN. Otherwise pulse `err_csum` and move to HUNT.
  - **DRAIN**: drive `out_valid=1`, `out_data=buf[rd_ptr]` and `out_last=(rd_ptr==len-1)`. On `out_valid&&out_ready`, increment `rd_ptr`. The handshake on the last byte moves to HUNT.
- Checksum is the 8-bit modular sum of the LEN byte and all payload bytes. The sync byte is excluded.
- Any `byte_valid` in DRAIN, including the cycle of the final handshake, drops the byte and pulses `err_ovr`.
- A sync byte seen inside LEN, PAYLOAD or CSUM is data, not a resync.
- Payload buffer contents are never cleared. They are only overwritten by the next frame.

## Timing
- Reset (synchronous, `rst_n` low at a `clk` edge):
  - State becomes HUNT.
  - Every output is 0, except `out_data`, which is don't-care.
  - Pointers, `sum`, `len` and the timeout counter are cleared.
  - Reset mid-frame or mid-drain discards the frame with no error pulse.
- State updates on the edge that samples `byte_valid`.
- `out_valid` rises on the cycle after the checksum byte is sampled.
- With `out_ready` held high, one byte transfers per cycle. An N-byte frame drains in N cycles.
- `busy` falls on the cycle after the last handshake.
- While `out_valid && !out_ready`, `out_data`, `out_last` and `msg_len` hold stable.
- `msg_len` is valid only while `out_valid` is high.
- Each error pulse occurs on the cycle after the offending byte or event. The return to HUNT happens on the same edge.

## Configuration
- The macro `UART_MSG_TIMEOUT_EN` controls the inter-byte timeout.
- Defined:
  - A counter of width `$clog2(TIMEOUT_CLKS+1)` runs only in LEN, PAYLOAD and CSUM.
  - It clears on entry to those states and on every `byte_valid`.
  - When it reaches `TIMEOUT_CLKS-1` with no byte that cycle, `err_timeout` pulses and the state moves to HUNT.
- Undefined: no counter is built, `err_timeout` is tied to 0, and a stalled frame waits indefinitely.

## Structure
- `uart_msg_pkg`: state enum (HUNT, LEN, PAYLOAD, CSUM, DRAIN), default `SYNC_BYTE`, and the `sum_t`/`len_t` typedefs (8-bit).
- Sub-module `uart_msg_buf`:
  - `MAX_LEN`×8 register file.
  - One synchronous write port and one combinational read port.
  - Write pointer and read pointer kept in the parent.
- The top level holds the FSM, checksum accumulator, pointers and timeout counter.

## Test plan
- **Good frame:** bytes 00 FF A5 03 11 22 33 69, `out_ready`=1.
  - `out_data`=11,22,33 on consecutive cycles.
  - `out_last` is high on 33 only; `msg_len`=3.
  - No error pulse.
- **Bad checksum:** same frame with a final byte of 68.
  - `err_csum` pulses once; `out_valid` stays 0; `busy` returns to 0.
- **Length bounds:**
  - A5 00 gives `err_len`.
  - A5 11 with `MAX_LEN`=16 gives `err_len`.
  - A5 10, 16 payload bytes and the correct checksum drain 16 bytes.
- **Backpressure:** good frame with `out_ready` low for 5 cycles after `out_valid` rises.
  - 11 is held stable for 5 cycles, then 11,22,33 transfer.
  - A byte injected during DRAIN gives `err_ovr` and the output is unchanged.
- **Timeout** (`UART_MSG_TIMEOUT_EN`, `TIMEOUT_CLKS`=50): A5 02 11 then 50 idle clocks.
  - `err_timeout` pulses once and the state returns to HUNT.
  - A following A5 01 7E 7F outputs 7E with `out_last`=1.
- **Reset mid-frame:** `rst_n` low for one cycle after A5 03 11.
  - All outputs are 0 and there are no error pulses.
  - The next good frame passes.
